// File: rtl/bcd_calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_calc_sequencer_if
// Brief    : Keypad handshake, datapath and display bundle of the BCD
//            calculator sequencer. The sequencer uses the slave modport.
// Revision : 1.0
// ============================================================================
interface bcd_calc_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       dp_sub;
    logic [7:0] dp_sum;
    logic       dp_cout;
    logic [3:0] disp10;
    logic [3:0] disp1;
    logic       disp_neg;
    logic       err;
    logic       busy;

    modport master (
        output key_valid, key_code, dp_sum, dp_cout,
        input  key_ready, dp_a, dp_b, dp_sub, disp10, disp1, disp_neg, err, busy
    );

    modport slave (
        input  key_valid, key_code, dp_sum, dp_cout,
        output key_ready, dp_a, dp_b, dp_sub, disp10, disp1, disp_neg, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_calc_sequencer
// Brief    : Keypad-driven control FSM for the two-digit BCD calculator.
//            Optional macro CALC_CHAIN_EN chains +/- from a shown result.
// Revision : 1.0
// ============================================================================
module bcd_calc_sequencer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_calc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_CONVERT = 3'd5,
        ST_SHOW    = 3'd6
    } state_t;

    localparam logic [3:0] c_key_plus    = 4'hA;
    localparam logic [3:0] c_key_minus   = 4'hB;
    localparam logic [3:0] c_key_eq      = 4'hC;
    localparam logic [3:0] c_key_clr     = 4'hD;
    localparam logic [3:0] c_err_digit   = 4'hE;
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a10, r_a1, r_b10, r_b1;
    logic       r_op;
    logic [7:0] r_dp_a, r_dp_b;
    logic       r_dp_sub;
    logic [3:0] r_cnt;
    logic [7:0] r_mag;
    logic [3:0] r_tens, r_ones;
    logic       r_neg, r_err;

    logic       w_key_ready, w_accept;
    logic       w_is_digit, w_is_op, w_is_eq, w_is_clr;
    logic       w_a_shift, w_a_new, w_a_load_res, w_b_shift, w_b_clr;
    logic       w_op_latch, w_clr_all;
    logic [3:0] w_disp10, w_disp1;

    assign w_key_ready = rst_n & ((r_state == ST_ENTRY_A) | (r_state == ST_ENTRY_B) |
                                  (r_state == ST_SHOW));
    assign w_accept    = bus.key_valid & w_key_ready;
    assign w_is_digit  = (bus.key_code <= 4'd9);
    assign w_is_op     = (bus.key_code == c_key_plus) | (bus.key_code == c_key_minus);
    assign w_is_eq     = (bus.key_code == c_key_eq);
    assign w_is_clr    = (bus.key_code == c_key_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ENTRY_A;
        else        r_state <= w_state_nxt;
    end

    // Next state plus one-cycle action strobes for the operand/result registers.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_shift    = 1'b0;
        w_a_new      = 1'b0;
        w_a_load_res = 1'b0;
        w_b_shift    = 1'b0;
        w_b_clr      = 1'b0;
        w_op_latch   = 1'b0;
        w_clr_all    = 1'b0;
        case (r_state)
            ST_ENTRY_A: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        w_a_shift = 1'b1;
                    end else if (w_is_op) begin
                        w_op_latch  = 1'b1;
                        w_b_clr     = 1'b1;
                        w_state_nxt = ST_ENTRY_B;
                    end else if (w_is_clr) begin
                        w_clr_all = 1'b1;
                    end
                end
            end
            ST_ENTRY_B: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        w_b_shift = 1'b1;
                    end else if (w_is_op) begin
                        w_op_latch = 1'b1;
                    end else if (w_is_eq) begin
                        w_state_nxt = ST_EXEC;
                    end else if (w_is_clr) begin
                        w_clr_all   = 1'b1;
                        w_state_nxt = ST_ENTRY_A;
                    end
                end
            end
            ST_EXEC:    w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == c_settle_last) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!r_dp_sub && (bus.dp_sum > 8'd99)) w_state_nxt = ST_SHOW;
                else                                   w_state_nxt = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (r_mag < 8'd10) w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        w_a_new     = 1'b1;
                        w_state_nxt = ST_ENTRY_A;
                    end else if (w_is_clr) begin
                        w_clr_all   = 1'b1;
                        w_state_nxt = ST_ENTRY_A;
                    end else if (w_is_op) begin
`ifdef CALC_CHAIN_EN
                        // Only a valid non-negative result fits back into operand A.
                        if (!r_neg && (r_tens != c_err_digit)) w_a_load_res = 1'b1;
                        else                                   w_clr_all    = 1'b1;
                        w_op_latch  = 1'b1;
                        w_b_clr     = 1'b1;
                        w_state_nxt = ST_ENTRY_B;
`endif
                    end
                end
            end
            default:    w_state_nxt = ST_ENTRY_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a10    <= 4'd0;
            r_a1     <= 4'd0;
            r_b10    <= 4'd0;
            r_b1     <= 4'd0;
            r_op     <= 1'b0;
            r_dp_a   <= 8'd0;
            r_dp_b   <= 8'd0;
            r_dp_sub <= 1'b0;
            r_cnt    <= 4'd0;
            r_mag    <= 8'd0;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_clr_all) begin
                r_a10 <= 4'd0;
                r_a1  <= 4'd0;
                r_b10 <= 4'd0;
                r_b1  <= 4'd0;
                r_err <= 1'b0;
                r_neg <= 1'b0;
            end
            if (w_a_shift) begin
                r_a10 <= r_a1;
                r_a1  <= bus.key_code;
            end
            if (w_a_new) begin
                r_a10 <= 4'd0;
                r_a1  <= bus.key_code;
                r_neg <= 1'b0;
            end
            if (w_a_load_res) begin
                r_a10 <= r_tens;
                r_a1  <= r_ones;
            end
            if (w_b_clr) begin
                r_b10 <= 4'd0;
                r_b1  <= 4'd0;
            end
            if (w_b_shift) begin
                r_b10 <= r_b1;
                r_b1  <= bus.key_code;
            end
            if (w_op_latch) r_op <= (bus.key_code == c_key_minus);

            case (r_state)
                ST_EXEC: begin
                    r_dp_a   <= {4'd0, r_a10} * 8'd10 + {4'd0, r_a1};
                    r_dp_b   <= {4'd0, r_b10} * 8'd10 + {4'd0, r_b1};
                    r_dp_sub <= r_op;
                    r_cnt    <= 4'd0;
                end
                ST_SETTLE:  r_cnt <= r_cnt + 4'd1;
                ST_CAPTURE: begin
                    r_tens <= 4'd0;
                    if (!r_dp_sub) begin
                        r_neg <= 1'b0;
                        r_mag <= bus.dp_sum;
                        if (bus.dp_sum > 8'd99) begin
                            r_err  <= 1'b1;
                            r_tens <= c_err_digit;
                            r_ones <= c_err_digit;
                        end
                    end else if (bus.dp_cout) begin
                        r_neg <= 1'b0;
                        r_mag <= bus.dp_sum;
                    end else begin
                        // No carry out means A < B: two's-complement the wrapped difference.
                        r_neg <= 1'b1;
                        r_mag <= ~bus.dp_sum + 8'd1;
                    end
                end
                ST_CONVERT: begin
                    if (r_mag >= 8'd10) begin
                        r_mag  <= r_mag - 8'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_mag[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_disp10 = r_b10;
        w_disp1  = r_b1;
        case (r_state)
            ST_ENTRY_A: begin
                w_disp10 = r_a10;
                w_disp1  = r_a1;
            end
            ST_SHOW: begin
                w_disp10 = r_tens;
                w_disp1  = r_ones;
            end
            default: ;
        endcase
    end

    assign bus.key_ready = w_key_ready;
    assign bus.dp_a      = r_dp_a;
    assign bus.dp_b      = r_dp_b;
    assign bus.dp_sub    = r_dp_sub;
    assign bus.disp10    = w_disp10;
    assign bus.disp1     = w_disp1;
    assign bus.disp_neg  = r_neg;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state == ST_EXEC) | (r_state == ST_SETTLE) |
                           (r_state == ST_CAPTURE) | (r_state == ST_CONVERT);
endmodule
`default_nettype wire

// File: doc/bcd_calc_sequencer.md
Name: bcd_calc_sequencer

Overview:
- Keypad-driven control FSM for the two-digit calculator.
- Collects operand A, an operator and operand B as BCD digits, converts each operand to 8-bit binary, and drives the shared 8-bit adder/subtractor datapath.
- Waits for the datapath to settle, captures sum/carry, then converts the result back to two BCD digits plus sign for the display.
- Sits between keypad decoder and 7-segment driver; the datapath is purely combinational.

Parameters:
SETTLE_CYC, 1, cycles dp_a/dp_b/dp_sub are held stable before dp_sum/dp_cout are sampled (1..15).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  key event present; held until accepted.
key_code  input  4  0-9 digit, A plus, B minus, C equals, D clear, E/F ignored (consumed, no effect).
key_ready  output  1  key accepted this cycle when key_valid and key_ready are both high.
dp_a  output  8  binary operand A to datapath.
dp_b  output  8  binary operand B to datapath.
dp_sub  output  1  1 = A-B (datapath inverts B, carry-in 1); 0 = A+B.
dp_sum  input  8  datapath sum.
dp_cout  input  1  datapath carry out.
disp10  output  4  tens BCD digit; E on error.
disp1  output  4  ones BCD digit; E on error.
disp_neg  output  1  minus sign.
err  output  1  sticky overflow flag.
busy  output  1  high in EXEC/SETTLE/CAPTURE/CONVERT.

Behaviour:
- Reset (async, rst_n low) forces ENTRY_A, all operands 00, op=plus, all outputs 0 (key_ready=0 only while rst_n low, 1 after).
- States: ENTRY_A, ENTRY_B, EXEC, SETTLE, CAPTURE, CONVERT, SHOW.
- key_ready = 1 in ENTRY_A, ENTRY_B and SHOW; 0 otherwise.
- Accepted keys in busy states never exist; a held key_valid waits.
- Digit entry: shift-in, tens<=ones, ones<=digit. A third digit drops the old tens digit.
- Display shows the operand under entry.
- ENTRY_A:
  - Digit edits A.
  - Plus/minus: latch op, clear B, go ENTRY_B.
  - Equals: ignored.
- ENTRY_B:
  - Digit edits B.
  - Plus/minus: replace op.
  - Equals: go EXEC.
- Clear (any state with key_ready): A=B=00, err=0, disp_neg=0, go ENTRY_A.
- EXEC (1 cycle): register dp_a = A10*10+A1, dp_b = B10*10+B1, dp_sub = op. Outputs hold through CAPTURE.
- SETTLE: count SETTLE_CYC cycles, then CAPTURE.
- CAPTURE (1 cycle): sample dp_sum/dp_cout into R, N.
  - Add: N=0, magnitude M=R. If R>99, err=1, disp=EE, go SHOW.
  - Sub: if dp_cout=1, N=0 and M=R. If dp_cout=0, N=1 and M=(~R)+1.
- CONVERT: one subtract-10 per cycle while M>=10, incrementing tens. Exits on the first cycle with M<10: ones=M. Takes tens+1 cycles.
- SHOW: disp10/disp1/disp_neg show the result.
  - Digit: start new A (A=00 then shift digit), clear result sign, go ENTRY_A.
  - Plus/minus: see optional feature.
  - Equals: ignored.
- Latency from equals acceptance to SHOW entry: 1 + SETTLE_CYC + 1 + (tens+1) cycles.
- Result -0 impossible: 00-00 gives cout=1, so N=0.
- rst_n assertion mid-compute aborts immediately; no partial result is shown.

Optional Feature:
CALC_CHAIN_EN:
- Defined: plus/minus in SHOW (non-error, non-negative result) loads A with the result digits, latches op, clears B, goes ENTRY_B.
- Defined, negative or error result: behaves like clear, then latches op.
- Undefined: plus/minus in SHOW are ignored (consumed).

Test Plan:
- Reset, then keys 4,2,+,1,7,= -> dp_a=0x2A, dp_b=0x11, dp_sub=0; SHOW with disp=5,9, disp_neg=0, err=0 after 1+SETTLE_CYC+1+6 cycles.
- Keys 1,5,-,4,0,= with datapath model -> dp_cout=0, disp=2,5, disp_neg=1.
- Keys 9,9,+,0,1,= -> R=100: err=1, disp=E,E; then clear -> err=0, disp=0,0.
- Keys 1,2,3 -> A shows 2,3; = in ENTRY_A ignored, busy stays 0.
- key_valid held with digit 7 during busy -> not accepted until SHOW; then the digit starts new A=07.
- Assert rst_n low during CONVERT -> all outputs 0 asynchronously, state ENTRY_A. Under CALC_CHAIN_EN: 3,0,+,5,=,+,5,= -> 4,0.
